// File: rtl/pe_accumulator_if.sv
// Bundle of the PE-row strobes, window control and result handshake of pe_accumulator.
// The slave modport is the accumulator side; master is whoever drives the PE row and sinks results.
interface pe_accumulator_if #(
  parameter int NUM_PE     = 9,
  parameter int PROD_WIDTH = 20,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                         start;
  logic [CNT_WIDTH-1:0]         beat_count;
  logic [NUM_PE*PROD_WIDTH-1:0] product_in;
  logic [NUM_PE-1:0]            ready_adder;
  logic [ACC_WIDTH-1:0]         acc_out;
  logic                         acc_valid;
  logic                         acc_ready;
  logic                         busy;
  logic                         overrun;

  modport master (
    output start, beat_count, product_in, ready_adder, acc_ready,
    input  acc_out, acc_valid, busy, overrun
  );

  modport slave (
    input  start, beat_count, product_in, ready_adder, acc_ready,
    output acc_out, acc_valid, busy, overrun
  );
endinterface

// File: rtl/pe_accumulator.sv
// Sums the masked PE products of each beat, accumulates beats over a programmable window
// and holds the finished partial sum in a valid/ready output register.
module pe_accumulator #(
  parameter int NUM_PE     = 9,
  parameter int PROD_WIDTH = 20,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst,
  pe_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t                       state, next_state;
  logic [CNT_WIDTH-1:0]         win_len, beat_cnt;
  logic                         start_ok, beat, first_beat, last_beat;
  logic signed [PROD_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]         masked_sum, lane_sum, acc, result;
  logic                         s1_valid, s1_first, s1_last;

  assign start_ok   = (state == IDLE) && bus.start;
  assign beat       = (state == ACCUM) && (|bus.ready_adder);
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = beat && (beat_cnt == (win_len - CNT_WIDTH'(1)));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok)             next_state = ACCUM;
      ACCUM:   if (last_beat)            next_state = FLUSH;
      FLUSH:   if (s1_valid && s1_last)  next_state = IDLE;
      default:                           next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A zero window length is promoted to one beat when latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_len  <= '0;
      beat_cnt <= '0;
    end else if (start_ok) begin
      win_len  <= (bus.beat_count == '0) ? CNT_WIDTH'(1) : bus.beat_count;
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    masked_sum = '0;
    prod       = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (bus.ready_adder[i]) begin
        prod       = bus.product_in[i*PROD_WIDTH +: PROD_WIDTH];
        masked_sum = masked_sum + ACC_WIDTH'(prod);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      lane_sum <= '0;
    end else begin
      s1_valid <= beat;
      s1_first <= beat && first_beat;
      s1_last  <= last_beat;
      if (beat) lane_sum <= masked_sum;
    end
  end

  assign result = s1_first ? lane_sum : (acc + lane_sum);

  always_ff @(posedge clk) begin
    if (rst)           acc <= '0;
    else if (s1_valid) acc <= result;
  end

  // The output register is independent of the window FSM; a result that finds it
  // still occupied and not being taken is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.acc_out   <= '0;
      bus.acc_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (start_ok) bus.overrun <= 1'b0;
      if (s1_valid && s1_last) begin
        if (!bus.acc_valid || bus.acc_ready) begin
          bus.acc_out   <= result;
          bus.acc_valid <= 1'b1;
        end else begin
          bus.overrun   <= 1'b1;
        end
      end else if (bus.acc_valid && bus.acc_ready) begin
        bus.acc_valid <= 1'b0;
      end
    end
  end

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_pe_accumulator.sv
// Self-checking bench for pe_accumulator: directed windows from the test plan plus random
// windows, with expected window sums queued at issue and popped on each output handshake.
module tb_pe_accumulator;

  localparam int NUM_PE = 9;
  localparam int PW     = 20;
  localparam int AW     = 32;
  localparam int AW2    = 20;
  localparam int CW     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_accumulator_if #(.NUM_PE(NUM_PE), .PROD_WIDTH(PW), .ACC_WIDTH(AW),  .CNT_WIDTH(CW)) bus  ();
  pe_accumulator_if #(.NUM_PE(NUM_PE), .PROD_WIDTH(PW), .ACC_WIDTH(AW2), .CNT_WIDTH(CW)) bus2 ();

  pe_accumulator #(.NUM_PE(NUM_PE), .PROD_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pe_accumulator #(.NUM_PE(NUM_PE), .PROD_WIDTH(PW), .ACC_WIDTH(AW2), .CNT_WIDTH(CW)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int             tests = 0;
  int             fails = 0;
  logic [AW-1:0]  exp_q[$];
  logic [AW2-1:0] exp2_q[$];
  longint         model_sum;
  int             lane_val[NUM_PE];
  bit             rnd_ready = 1'b0;

  function automatic logic [AW-1:0] wrap_acc(input longint s);
    return s[AW-1:0];
  endfunction

  task automatic check_output(input string name, input logic signed [63:0] actual,
                              input logic signed [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard: every handshake on the output consumes the oldest expected window sum.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    if (rst === 1'b0 && bus.acc_valid === 1'b1 && bus.acc_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL scoreboard: got unexpected result %0d, expected none", $signed(bus.acc_out));
      end else begin
        e = exp_q.pop_front();
        if (bus.acc_out !== e) begin
          fails++;
          $display("[TB] FAIL scoreboard: got %0d, expected %0d", $signed(bus.acc_out), $signed(e));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [AW2-1:0] e;
    if (rst === 1'b0 && bus2.acc_valid === 1'b1 && bus2.acc_ready === 1'b1) begin
      tests++;
      if (exp2_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL scoreboard2: got unexpected result %0d, expected none", $signed(bus2.acc_out));
      end else begin
        e = exp2_q.pop_front();
        if (bus2.acc_out !== e) begin
          fails++;
          $display("[TB] FAIL scoreboard2: got %0d, expected %0d", $signed(bus2.acc_out), $signed(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.acc_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < NUM_PE; i++) lane_val[i] = int'($urandom_range(0, 1048575)) - 524288;
  endtask

  task automatic set_lanes(input int v);
    for (int i = 0; i < NUM_PE; i++) lane_val[i] = v;
  endtask

  task automatic drive_lanes(input logic [NUM_PE-1:0] mask);
    for (int i = 0; i < NUM_PE; i++) bus.product_in[i*PW +: PW] = lane_val[i][PW-1:0];
    bus.ready_adder = mask;
  endtask

  task automatic apply_stimulus(input logic [NUM_PE-1:0] mask, input bit counted);
    drive_lanes(mask);
    if (counted)
      for (int i = 0; i < NUM_PE; i++) if (mask[i]) model_sum += longint'(lane_val[i]);
    tick();
    bus.ready_adder = '0;
    bus.start       = 1'b0;
  endtask

  // The random strobes issued alongside start must be ignored by the block.
  task automatic do_start(input int cnt);
    bus.start      = 1'b1;
    bus.beat_count = CW'(cnt);
    rand_lanes();
    model_sum = 0;
    apply_stimulus(9'h1FF, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      rand_lanes();
      drive_lanes('0);
      tick();
    end
  endtask

  task automatic push_expected();
    exp_q.push_back(wrap_acc(model_sum));
  endtask

  initial begin
    logic [NUM_PE-1:0] m;
    int                cnt, nb, guard;
    longint            s2;

    bus.start = 1'b0;  bus.beat_count = '0;  bus.product_in = '0;  bus.ready_adder = '0;
    bus.acc_ready = 1'b1;
    bus2.start = 1'b0; bus2.beat_count = '0; bus2.product_in = '0; bus2.ready_adder = '0;
    bus2.acc_ready = 1'b1;

    tick(); tick();
    rst = 1'b0;
    check_output("reset_acc_out",   $signed(bus.acc_out), 0);
    check_output("reset_acc_valid", bus.acc_valid, 0);
    check_output("reset_busy",      bus.busy, 0);
    check_output("reset_overrun",   bus.overrun, 0);

    // Single window: 3 beats of nine lanes at 2.
    do_start(3);
    set_lanes(2);
    for (int b = 0; b < 3; b++) apply_stimulus(9'h1FF, 1'b1);
    push_expected();
    check_output("single_flush_busy",  bus.busy, 1);
    check_output("single_flush_valid", bus.acc_valid, 0);
    tick();
    check_output("single_valid_t2", bus.acc_valid, 1);
    check_output("single_busy_t2",  bus.busy, 0);
    check_output("single_value",    $signed(bus.acc_out), 54);
    gap(1);

    // Masking and strobe-free gaps.
    do_start(2);
    set_lanes(100);
    lane_val[0] = -5;
    apply_stimulus(9'h001, 1'b1);
    gap(3);
    check_output("gap_still_busy", bus.busy, 1);
    set_lanes(1);
    apply_stimulus(9'h1FF, 1'b1);
    push_expected();
    tick();
    check_output("mask_value", $signed(bus.acc_out), 4);
    check_output("mask_valid", bus.acc_valid, 1);
    gap(1);

    // Most negative products on every lane.
    do_start(1);
    set_lanes(-524288);
    apply_stimulus(9'h1FF, 1'b1);
    push_expected();
    tick();
    check_output("neg_extreme", $signed(bus.acc_out), -4718592);
    gap(1);

    // Start during ACCUM must neither restart nor re-sample the window length.
    do_start(3);
    rand_lanes();
    apply_stimulus(9'h1FF, 1'b1);
    bus.start      = 1'b1;
    bus.beat_count = CW'(1);
    rand_lanes();
    apply_stimulus(9'h0F3, 1'b1);
    gap(1);
    check_output("ign_start_busy",  bus.busy, 1);
    check_output("ign_start_valid", bus.acc_valid, 0);
    rand_lanes();
    apply_stimulus(9'h1FF, 1'b1);
    push_expected();
    gap(2);

    // Random windows with random backpressure.
    rnd_ready = 1'b1;
    for (int w = 0; w < 20; w++) begin
      cnt = int'($urandom_range(0, 6));
      nb  = (cnt == 0) ? 1 : cnt;
      do_start(cnt);
      for (int b = 0; b < nb; b++) begin
        gap(int'($urandom_range(0, 2)));
        rand_lanes();
        m = NUM_PE'($urandom_range(1, 511));
        if ($urandom_range(0, 3) == 0) m = 9'h1FF;
        apply_stimulus(m, 1'b1);
      end
      push_expected();
      gap(2);
      guard = 0;
      while (bus.acc_valid === 1'b1 && guard < 200) begin
        tick();
        guard++;
      end
      check_output("random_drain", bus.acc_valid, 0);
    end
    rnd_ready     = 1'b0;
    bus.acc_ready = 1'b1;
    check_output("random_no_overrun", bus.overrun, 0);

    // Backpressure: the second result is dropped and flagged.
    bus.acc_ready = 1'b0;
    do_start(1);
    set_lanes(0);
    lane_val[0] = 10;
    apply_stimulus(9'h001, 1'b1);
    push_expected();
    gap(3);
    do_start(1);
    set_lanes(0);
    lane_val[0] = 20;
    apply_stimulus(9'h001, 1'b1);
    tick();
    check_output("overrun_set",     bus.overrun, 1);
    check_output("bp_hold_value",   $signed(bus.acc_out), 10);
    check_output("bp_hold_valid",   bus.acc_valid, 1);
    gap(2);
    check_output("bp_stable_value", $signed(bus.acc_out), 10);
    bus.acc_ready = 1'b1;
    tick();
    bus.acc_ready = 1'b0;
    check_output("bp_release_valid", bus.acc_valid, 0);
    check_output("overrun_sticky",   bus.overrun, 1);
    do_start(1);
    check_output("overrun_clear", bus.overrun, 0);
    set_lanes(0);
    lane_val[0] = 10;
    apply_stimulus(9'h001, 1'b1);
    push_expected();
    gap(2);

    // Take of the held result in the very cycle the next result loads.
    do_start(1);
    set_lanes(0);
    lane_val[0] = 20;
    apply_stimulus(9'h001, 1'b1);
    push_expected();
    bus.acc_ready = 1'b1;
    tick();
    bus.acc_ready = 1'b0;
    check_output("take_load_valid",   bus.acc_valid, 1);
    check_output("take_load_value",   $signed(bus.acc_out), 20);
    check_output("take_load_overrun", bus.overrun, 0);
    gap(1);

    // Reset mid-window discards the window and the held result.
    do_start(3);
    rand_lanes();
    apply_stimulus(9'h1FF, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_output("midrst_acc_out",   $signed(bus.acc_out), 0);
    check_output("midrst_acc_valid", bus.acc_valid, 0);
    check_output("midrst_busy",      bus.busy, 0);
    check_output("midrst_overrun",   bus.overrun, 0);

    // A zero window length accepts exactly one beat.
    bus.acc_ready = 1'b1;
    do_start(0);
    rand_lanes();
    apply_stimulus(9'h15A, 1'b1);
    push_expected();
    tick();
    check_output("cnt0_busy_t2",  bus.busy, 0);
    check_output("cnt0_valid_t2", bus.acc_valid, 1);
    rand_lanes();
    apply_stimulus(9'h1FF, 1'b0);
    gap(2);
    check_output("idle_beat_ignored", bus.acc_valid, 0);

    // Narrow accumulator: nine maximum products wrap modulo 2^20.
    bus2.start      = 1'b1;
    bus2.beat_count = CW'(1);
    tick();
    bus2.start = 1'b0;
    s2 = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      bus2.product_in[i*PW +: PW] = 20'h7FFFF;
      s2 += 524287;
    end
    bus2.ready_adder = 9'h1FF;
    exp2_q.push_back(s2[AW2-1:0]);
    tick();
    bus2.ready_adder = '0;
    tick();
    check_output("wrap_value", $signed(bus2.acc_out), 524279);
    tick();
    gap(2);

    check_output("scoreboard_empty", exp_q.size() + exp2_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
